// File: rtl/imem_loader_if.sv
// Byte-stream input, instruction-memory write port and load status of the image loader.
// master = loader side, slave = source/memory/core side.
interface imem_loader_if #(
    parameter int ADDR_W = 8
);
    logic              start;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        input  start, byte_valid, byte_data,
        output byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error
    );

    modport slave (
        output start, byte_valid, byte_data,
        input  byte_ready, wr_en, wr_addr, wr_data, cpu_hold, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: length-prefixed byte stream -> little-endian 32-bit word writes.
// Keeps the core in reset until a complete, well-formed image has been written.
module imem_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 256
) (
    input logic            clk,
    input logic            reset,
    imem_loader_if.master  bus
);
    typedef enum logic [2:0] {
        IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERR
    } state_t;

    state_t          state;
    logic [15:0]     len;
    logic [ADDR_W:0] cnt;   // one extra bit so len == 2**ADDR_W is representable
    logic [1:0]      idx;
    logic [23:0]     word;  // byte 3 goes straight into wr_data

    logic        xfer;
    logic [15:0] new_len;
    logic [15:0] cnt_next;

    assign xfer     = bus.byte_valid && bus.byte_ready;
    assign new_len  = {bus.byte_data, len[7:0]};
    assign cnt_next = 16'(cnt) + 16'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            len            <= '0;
            cnt            <= '0;
            idx            <= '0;
            word           <= '0;
            bus.byte_ready <= 1'b0;
            bus.wr_en      <= 1'b0;
            bus.wr_addr    <= '0;
            bus.wr_data    <= '0;
            bus.cpu_hold   <= 1'b1;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (bus.start) begin
                        state          <= LEN_LO;
                        bus.byte_ready <= 1'b1;
                        bus.busy       <= 1'b1;
                        bus.cpu_hold   <= 1'b1;
                        bus.done       <= 1'b0;
                        bus.error      <= 1'b0;
                    end
                end
                LEN_LO: begin
                    if (xfer) begin
                        len[7:0] <= bus.byte_data;
                        state    <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (xfer) begin
                        len[15:8] <= bus.byte_data;
                        if (new_len == 16'd0 || new_len > 16'(MAX_WORDS)) begin
                            state          <= ERR;
                            bus.byte_ready <= 1'b0;
                            bus.busy       <= 1'b0;
                            bus.error      <= 1'b1;
                        end else begin
                            state <= DATA;
                            cnt   <= '0;
                            idx   <= '0;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        idx <= idx + 2'd1;
                        case (idx)
                            2'd0: word[7:0]   <= bus.byte_data;
                            2'd1: word[15:8]  <= bus.byte_data;
                            2'd2: word[23:16] <= bus.byte_data;
                            default: begin
                                state          <= WRITE;
                                bus.byte_ready <= 1'b0;
                                bus.wr_en      <= 1'b1;
                                bus.wr_addr    <= cnt[ADDR_W-1:0];
                                bus.wr_data    <= {bus.byte_data, word};
                            end
                        endcase
                    end
                end
                WRITE: begin
                    bus.wr_en <= 1'b0;
                    if (cnt_next == len) begin
                        state        <= DONE;
                        bus.busy     <= 1'b0;
                        bus.done     <= 1'b1;
                        bus.cpu_hold <= 1'b0;
                    end else begin
                        state          <= DATA;
                        cnt            <= cnt + 1'b1;
                        idx            <= '0;
                        bus.byte_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
